// File: rtl/custom_bloom_unit.sv
// -----------------------------------------------------------------------------
// custom_bloom_unit
//   Bloom-filter coprocessor. Keys are hashed NUM_HASH ways into a
//   FILTER_BITS-bit filter held as WORDS 32-bit registers. Each accepted
//   command runs in its own FSM state and finishes with a single DONE cycle
//   that carries the result.
//
//   Commands (custom_op_i):
//     00001 INSERT : set h_0..h_{N-1}, one per cycle; bump saturating counter
//     00011 CLEAR  : zero word 0..WORDS-1, one per cycle; counter -> 0
//     00100 CHECK  : AND of bits h_0..h_{N-1}, result {31'b0, hit}
//     00101 COUNT  : result {16'b0, insert_count}
//     others       : illegal, result 0, no state change
//
//   Handshake: a command is taken on a rising edge when custom_en_i = 1 and
//   the FSM is in IDLE or DONE (busy_o = 0). While busy_o = 1 custom_en_i is
//   ignored. custom_valid_o is a one-cycle pulse (the DONE state) and
//   custom_result_o is 0 whenever custom_valid_o = 0.
//
//   Ports:
//     clk_i, rst_ni      clock, asynchronous active-low reset
//     custom_en_i        command request
//     custom_op_i[4:0]   opcode
//     custom_rs1_i       key
//     custom_rs2_i       reserved, ignored
//     busy_o             command in progress (INSERT/CHECK/CLEAR)
//     custom_valid_o     completion pulse
//     custom_result_o    result, valid with custom_valid_o
//     dbg_state_o        current FSM state (IDLE=0 INSERT=1 CHECK=2 CLEAR=3 DONE=4)
//     dbg_op_o           last latched opcode
// -----------------------------------------------------------------------------
module custom_bloom_unit #(
  parameter int DATA_W      = 32,
  parameter int FILTER_BITS = 256,
  parameter int NUM_HASH    = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              custom_en_i,
  input  logic [4:0]        custom_op_i,
  input  logic [DATA_W-1:0] custom_rs1_i,
  input  logic [DATA_W-1:0] custom_rs2_i,
  output logic              busy_o,
  output logic              custom_valid_o,
  output logic [31:0]       custom_result_o,
  output logic [2:0]        dbg_state_o,
  output logic [4:0]        dbg_op_o
);

  localparam int IDX_W = $clog2(FILTER_BITS);
  localparam int WORDS = FILTER_BITS / 32;
  localparam int WW    = IDX_W - 5;            // word-index width
  localparam int SW    = (WW > 2) ? WW : 2;    // step counter covers words and hashes

  localparam logic [4:0] OP_INSERT = 5'b00001;
  localparam logic [4:0] OP_CLEAR  = 5'b00011;
  localparam logic [4:0] OP_CHECK  = 5'b00100;
  localparam logic [4:0] OP_COUNT  = 5'b00101;

  localparam logic [SW-1:0] LAST_H = SW'(NUM_HASH - 1);
  localparam logic [SW-1:0] LAST_W = SW'(WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INSERT = 3'd1,
    S_CHECK  = 3'd2,
    S_CLEAR  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              state_q;
  logic [4:0]          op_q;
  logic [DATA_W-1:0]   key_q;
  logic [SW-1:0]       step_q;
  logic                acc_q;
  logic [15:0]         cnt_q;
  logic [31:0]         result_q;
  logic [31:0]         filter_q [WORDS];

  // rs2 is reserved for a later revision.
  logic rs2_unused;
  assign rs2_unused = ^custom_rs2_i;

  // h_k = low IDX_W bits of (r ^ (r >> IDX_W)), r = rotl(key, 8k).
  function automatic logic [IDX_W-1:0] bloom_hash(input logic [DATA_W-1:0] key,
                                                  input int k);
    int                sh;
    logic [DATA_W-1:0] r;
    sh = (8 * k) % DATA_W;
    // A shift by DATA_W yields 0, so sh = 0 degenerates to r = key.
    r  = (key << sh) | (key >> (DATA_W - sh));
    return IDX_W'(r ^ (r >> IDX_W));
  endfunction

  // All four possible hashes of the latched key; step_q picks the live one.
  logic [IDX_W-1:0] hash_k [4];
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      hash_k[k] = bloom_hash(key_q, k);
    end
  end

  logic [IDX_W-1:0] cur_hash;
  logic [WW-1:0]    cur_word;
  logic [4:0]       cur_bit_idx;
  logic             cur_bit;
  logic             acc_next;

  assign cur_hash    = hash_k[step_q[1:0]];
  assign cur_word    = cur_hash[IDX_W-1:5];
  assign cur_bit_idx = cur_hash[4:0];
  assign cur_bit     = filter_q[cur_word][cur_bit_idx];
  assign acc_next    = acc_q & cur_bit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      key_q    <= '0;
      step_q   <= '0;
      acc_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      for (int w = 0; w < WORDS; w++) begin
        filter_q[w] <= '0;
      end
    end else begin
      // The result only lives for the DONE cycle; every other edge clears it.
      result_q <= '0;
      case (state_q)
        S_INSERT: begin
          // Repeated hashes just set the same bit again.
          filter_q[cur_word][cur_bit_idx] <= 1'b1;
          if (step_q == LAST_H) begin
            state_q <= S_DONE;
          end else begin
            step_q <= step_q + SW'(1);
          end
        end
        S_CHECK: begin
          acc_q <= acc_next;
          if (step_q == LAST_H) begin
            state_q  <= S_DONE;
            result_q <= {31'b0, acc_next};
          end else begin
            step_q <= step_q + SW'(1);
          end
        end
        S_CLEAR: begin
          filter_q[step_q[WW-1:0]] <= '0;
          if (step_q == '0) begin
            cnt_q <= '0;
          end
          if (step_q == LAST_W) begin
            state_q <= S_DONE;
          end else begin
            step_q <= step_q + SW'(1);
          end
        end
        default: begin
          // IDLE and DONE both accept; DONE chains straight into the next command.
          state_q <= S_IDLE;
          if (custom_en_i) begin
            op_q   <= custom_op_i;
            key_q  <= custom_rs1_i;
            step_q <= '0;
            case (custom_op_i)
              OP_INSERT: begin
                state_q <= S_INSERT;
                if (cnt_q != 16'hFFFF) begin
                  cnt_q <= cnt_q + 16'd1;
                end
              end
              OP_CHECK: begin
                state_q <= S_CHECK;
                acc_q   <= 1'b1;
              end
              OP_CLEAR: begin
                state_q <= S_CLEAR;
              end
              OP_COUNT: begin
                state_q  <= S_DONE;
                result_q <= {16'b0, cnt_q};
              end
              default: begin
                state_q <= S_DONE;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign busy_o          = (state_q == S_INSERT) || (state_q == S_CHECK) ||
                           (state_q == S_CLEAR);
  assign custom_valid_o  = (state_q == S_DONE);
  assign custom_result_o = result_q;
  assign dbg_state_o     = state_q;
  assign dbg_op_o        = op_q;

endmodule

// File: tb/tb_custom_bloom_unit.sv
// -----------------------------------------------------------------------------
// tb_custom_bloom_unit
//   Scoreboard bench for custom_bloom_unit with default parameters. The driver
//   pushes the expected result, latency and acceptance cycle for every command;
//   a monitor pops and compares on each custom_valid_o pulse. Expected values
//   come from a bit-array model of the filter and an integer counter.
// -----------------------------------------------------------------------------
module tb_custom_bloom_unit;

  localparam int DATA_W      = 32;
  localparam int FILTER_BITS = 256;
  localparam int NUM_HASH    = 2;
  localparam int IDX_W       = 8;
  localparam int WORDS       = 8;

  localparam logic [4:0] OP_INSERT = 5'b00001;
  localparam logic [4:0] OP_CLEAR  = 5'b00011;
  localparam logic [4:0] OP_CHECK  = 5'b00100;
  localparam logic [4:0] OP_COUNT  = 5'b00101;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic [4:0]        op = '0;
  logic [DATA_W-1:0] rs1 = '0;
  logic [DATA_W-1:0] rs2 = '0;
  logic              busy;
  logic              valid;
  logic [31:0]       result;
  logic [2:0]        dbg_state;
  logic [4:0]        dbg_op;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  custom_bloom_unit #(
    .DATA_W     (DATA_W),
    .FILTER_BITS(FILTER_BITS),
    .NUM_HASH   (NUM_HASH)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .custom_en_i    (en),
    .custom_op_i    (op),
    .custom_rs1_i   (rs1),
    .custom_rs2_i   (rs2),
    .busy_o         (busy),
    .custom_valid_o (valid),
    .custom_result_o(result),
    .dbg_state_o    (dbg_state),
    .dbg_op_o       (dbg_op)
  );

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          acc_cyc_q[$];
  int          n_checks = 0;
  int          n_pass = 0;

  // Reference model: one bit per filter position and a plain counter.
  bit          mf [FILTER_BITS];
  int          mcnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  // rotl taken as a window of the doubled key, then folded and reduced mod filter size.
  function automatic int mhash(input logic [31:0] key, input int k);
    int          s;
    logic [63:0] dbl;
    logic [31:0] r;
    s   = (8 * k) % 32;
    dbl = {key, key};
    r   = dbl[63-s -: 32];
    return int'((r ^ (r >> IDX_W)) % FILTER_BITS);
  endfunction

  function automatic logic [31:0] model_word(input int w);
    logic [31:0] v;
    v = '0;
    for (int b = 0; b < 32; b++) v[b] = mf[w*32 + b];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < FILTER_BITS; i++) mf[i] = 1'b0;
    mcnt = 0;
  endtask

  task automatic check_filter(input string name);
    for (int w = 0; w < WORDS; w++) check(name, dut.filter_q[w], model_word(w));
  endtask

  // ---------------- driver ----------------
  // Call at a negedge. Waits for busy_o = 0, drives one command for one cycle.
  task automatic do_cmd(input logic [4:0] c_op, input logic [31:0] key);
    int          budget;
    logic [31:0] exp;
    int          lat;
    bit          hit;
    budget = 0;
    while (busy && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    n_checks++;
    if (budget < 200) n_pass++;
    else $display("FAIL busy_wait: still busy after %0d cycles, required idle", budget);
    case (c_op)
      OP_INSERT: begin
        for (int k = 0; k < NUM_HASH; k++) mf[mhash(key, k)] = 1'b1;
        if (mcnt < 'hFFFF) mcnt++;
        exp = '0;
        lat = NUM_HASH + 1;
      end
      OP_CHECK: begin
        hit = 1'b1;
        for (int k = 0; k < NUM_HASH; k++) hit = hit & mf[mhash(key, k)];
        exp = {31'b0, hit};
        lat = NUM_HASH + 1;
      end
      OP_CLEAR: begin
        for (int i = 0; i < FILTER_BITS; i++) mf[i] = 1'b0;
        mcnt = 0;
        exp = '0;
        lat = WORDS + 1;
      end
      OP_COUNT: begin
        exp = 32'(mcnt);
        lat = 1;
      end
      default: begin
        exp = '0;
        lat = 1;
      end
    endcase
    exp_q.push_back(exp);
    lat_q.push_back(lat);
    acc_cyc_q.push_back(cyc + 1);
    en  = 1'b1;
    op  = c_op;
    rs1 = key;
    rs2 = $urandom;
    @(negedge clk);
    en  = 1'b0;
  endtask

  function automatic logic [4:0] rand_illegal();
    logic [4:0] v;
    v = 5'($urandom_range(0, 31));
    while (v == OP_INSERT || v == OP_CLEAR || v == OP_CHECK || v == OP_COUNT)
      v = 5'($urandom_range(0, 31));
    return v;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_valid: got valid with result 0x%08h, required no pulse", result);
        end else begin
          logic [31:0] e;
          int          l;
          int          a;
          e = exp_q.pop_front();
          l = lat_q.pop_front();
          a = acc_cyc_q.pop_front();
          check("result", result, e);
          check("latency", 32'(cyc - a + 1), 32'(l));
        end
      end else begin
        check("result_idle_zero", result, 32'h0);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] key_pool [8];

  initial begin
    model_reset();
    for (int i = 0; i < 8; i++) key_pool[i] = $urandom;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_valid", {31'b0, valid}, 32'h0);
    check("rst_result", result, 32'h0);
    check("rst_state", {29'b0, dbg_state}, 32'h0);
    check_filter("rst_filter");
    rst_n = 1'b1;

    // Known-answer insert: bits 46 and 106 only, busy for two cycles
    do_cmd(OP_INSERT, 32'h12345678);
    check("ins_busy_c1", {31'b0, busy}, 32'h1);
    @(negedge clk);
    check("ins_busy_c2", {31'b0, busy}, 32'h1);
    @(negedge clk);
    check("ins_busy_done", {31'b0, busy}, 32'h0);
    for (int w = 0; w < WORDS; w++) begin
      logic [31:0] lit;
      lit = (w == 1) ? 32'h0000_4000 : (w == 3) ? 32'h0000_0400 : 32'h0;
      check("kat_filter", dut.filter_q[w], lit);
    end

    do_cmd(OP_CHECK, 32'h12345678);   // -> 1
    do_cmd(OP_CHECK, 32'h00000000);   // h0 = h1 = 0 -> 0
    do_cmd(OP_INSERT, key_pool[0]);
    do_cmd(OP_INSERT, key_pool[1]);
    do_cmd(OP_COUNT, '0);             // -> 3
    do_cmd(OP_CLEAR, '0);
    do_cmd(OP_COUNT, '0);             // -> 0
    do_cmd(OP_CHECK, 32'h12345678);   // -> 0
    do_cmd(OP_INSERT, 32'h0);         // duplicate hash sets bit 0 once
    do_cmd(OP_CHECK, 32'h0);          // -> 1
    do_cmd(OP_COUNT, '0);
    repeat (2) @(negedge clk);
    check_filter("after_dup");

    // Request while busy is ignored: only the INSERT pulses
    do_cmd(OP_INSERT, key_pool[2]);
    en = 1'b1; op = OP_CHECK; rs1 = key_pool[2];
    @(negedge clk);
    en = 1'b0;
    repeat (6) @(negedge clk);
    check("busy_ignore_drained", 32'(exp_q.size()), 32'h0);

    // Reset in cycle 4 of a CLEAR: no pulse, everything zero
    do_cmd(OP_INSERT, key_pool[3]);
    do_cmd(OP_CLEAR, '0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midclr_busy", {31'b0, busy}, 32'h0);
    check("midclr_valid", {31'b0, valid}, 32'h0);
    check("midclr_result", result, 32'h0);
    exp_q.delete(); lat_q.delete(); acc_cyc_q.delete();
    model_reset();
    check_filter("midclr_filter");
    @(negedge clk);
    rst_n = 1'b1;
    do_cmd(OP_INSERT, key_pool[4]);
    do_cmd(5'h1F, key_pool[4]);       // illegal -> 0, one-cycle latency
    do_cmd(OP_COUNT, '0);             // counter unchanged by illegal -> 1

    // Back-to-back INSERT then CHECK of the same key in the DONE cycle
    for (int i = 0; i < 6; i++) begin
      logic [31:0] k;
      k = $urandom;
      do_cmd(OP_INSERT, k);
      do_cmd(OP_CHECK, k);
    end

    // Randomised mix
    for (int i = 0; i < 200; i++) begin
      int          sel;
      logic [31:0] k;
      sel = $urandom_range(0, 99);
      k   = ($urandom_range(0, 1) == 1) ? key_pool[$urandom_range(0, 7)] : $urandom;
      if      (sel < 35) do_cmd(OP_INSERT, k);
      else if (sel < 75) do_cmd(OP_CHECK, k);
      else if (sel < 85) do_cmd(OP_COUNT, k);
      else if (sel < 92) do_cmd(rand_illegal(), k);
      else               do_cmd(OP_CLEAR, k);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    // Saturation: preload the counter just below the limit
    while (busy) @(negedge clk);
    @(negedge clk);
    force dut.cnt_q = 16'hFFFD;
    #1 release dut.cnt_q;
    mcnt = 'hFFFD;
    do_cmd(OP_INSERT, key_pool[5]);
    do_cmd(OP_INSERT, key_pool[6]);
    do_cmd(OP_INSERT, key_pool[7]);
    do_cmd(OP_INSERT, key_pool[7]);
    do_cmd(OP_COUNT, '0);             // -> 0xFFFF
    do_cmd(rand_illegal(), '0);
    do_cmd(OP_COUNT, '0);             // still 0xFFFF
    do_cmd(OP_CLEAR, '0);
    do_cmd(OP_COUNT, '0);             // -> 0

    // Drain
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_empty", 32'(exp_q.size()), 32'h0);
    repeat (3) @(negedge clk);
    check_filter("final_filter");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
